ibexc_rvfi_trace_packer: RTL
============================

# ibexc_rvfi_trace_packer

Captures retired-instruction records from the core's RVFI port and buffers them in a small record FIFO. Each record is serialized into a variable-length stream of 32-bit trace words with valid/ready handshaking. It sits beside `ibex_tracer` on the RVFI bus of the tracing top, downstream of the core. It gives on-chip and FPGA builds a compact, back-pressurable instruction trace. When the sink stalls, records are dropped and the loss is reported in-band; the core is never stalled.

## Interface

- `Depth`, 4: record FIFO entries; power of two, ≥2.
- `DropCntW`, 16: width of the drop counters; saturating.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `enable_i`  in  1  capture enable.
- `rvfi_valid`  in  1  a retired record is present this cycle.
- `rvfi_order`  in  64  retire order; bits [9:0] are used.
- `rvfi_pc_rdata`  in  32  PC of the retired instruction.
- `rvfi_insn`  in  32  instruction word.
- `rvfi_trap`, `rvfi_intr`  in  1 each  trap and interrupt flags.
- `rvfi_rd_addr`  in  5  destination register.
- `rvfi_rd_wdata`  in  32  destination write data.
- `rvfi_mem_addr`  in  32  memory address.
- `rvfi_mem_rmask`, `rvfi_mem_wmask`  in  4 each  memory read and write byte masks.
- `rvfi_mem_is_cap`  in  1  the memory access is a capability access.
- `trace_valid_o`  out  1  a trace word is valid.
- `trace_ready_i`  in  1  the sink accepts the word.
- `trace_data_o`  out  32  trace word.
- `trace_last_o`  out  1  final word of a record.
- `drop_cnt_o`  out  DropCntW  total records dropped since reset; saturates.
- `fifo_level_o`  out  $clog2(Depth+1)  number of occupied entries.

## Operation

**Capture**
- A record is captured when `rvfi_valid & enable_i`.
- If the registered level is below `Depth`, the record is pushed.
- Otherwise the record is dropped:
  - `pend_drop` increments, saturating at all-ones.
  - `drop_cnt_o` increments, saturating at all-ones.
- Fullness is judged on the registered level only. A push into a full FIFO is dropped even if a pop completes in the same cycle.
- Each pushed entry stores `pend_drop` as its `drops_before` field. `pend_drop` then clears to 0, except that a drop in the same cycle cannot occur, since push and drop are exclusive.
- With `enable_i` low, nothing is captured or counted. The serializer keeps draining.

**Record word sequence** (one beat per word; `trace_last_o` is asserted on the final word only)
1. DROP word, only if `drops_before != 0`:
   - [31:28]=4'hD
   - [27:DropCntW]=0
   - [DropCntW-1:0]=`drops_before`
2. HDR word:
   - [31:28]=4'hA
   - [27]=trap
   - [26]=intr
   - [25]=has_rd, defined as rd_addr≠0
   - [24]=has_mem, defined as (rmask|wmask)≠0
   - [23]=mem_is_cap
   - [22:18]=rd_addr
   - [17:14]=rmask
   - [13:10]=wmask
   - [9:0]=order[9:0]
3. PC word: `rvfi_pc_rdata`.
4. INSN word: `rvfi_insn`.
5. RD word: `rvfi_rd_wdata`, only if has_rd.
6. MEM word: `rvfi_mem_addr`, only if has_mem.

A record is therefore 3–6 words long.

**Serializer FSM**
- States: IDLE, DROP, HDR, PC, INSN, RD, MEM.
- From IDLE with the FIFO non-empty, go to DROP if `drops_before≠0`, otherwise to HDR.
- Each state advances on `trace_valid_o & trace_ready_i` to the next present word, skipping absent RD/MEM words.
- After the last word:
  - the head entry pops;
  - the FSM goes to the next record's first state if another entry is present, otherwise to IDLE.
- `trace_valid_o` is high in every state except IDLE. `trace_data_o` is selected combinationally from the FIFO head and the current state.

**Reset**
- In the cycle after `rst_i` is sampled high:
  - all outputs are 0;
  - the FIFO is empty;
  - the FSM is in IDLE;
  - `pend_drop` and `drop_cnt_o` are 0.
- A reset mid-record discards the partial record with no `trace_last_o`. The sink must resynchronize on the next HDR word.

## Timing

- A record sampled at edge N is visible on `trace_valid_o` and `trace_data_o` in the cycle after N. There are no further pipeline stages.
- Throughput is one word per cycle while `trace_ready_i` is high. There are no bubbles between records.
- While `trace_valid_o & !trace_ready_i`, `trace_data_o`, `trace_last_o` and the FSM state are held stable.
- `fifo_level_o` updates at the push or pop edge.
  - A simultaneous push and pop leaves the level unchanged.
  - The pop occurs on the edge that accepts a record's last word.
- Sustained capture of one record per cycle exceeds output bandwidth. Drops are expected and are not an error.

## Test plan

- **ALU record:** `rvfi_valid` for 1 cycle, pc=0x8000_0000, insn=0x0020_81B3, rd=3, wdata=0x1234, order=5, masks=0, `trace_ready_i`=1 → 4 beats 0xA20C_0005, 0x8000_0000, 0x0020_81B3, 0x0000_1234; `trace_last_o` on beat 4; beat 1 in the cycle after capture.
- **Capability store with x0:** rd=0, wmask=0xF, is_cap=1, mem_addr=0x2001_0040, order=0 → 4 beats, HDR=0xA180_3C00, MEM word 0x2001_0040 last; no RD word.
- **Back-pressure:** `trace_ready_i` toggles 1,0,0,1,… during an ALU record → the word is held stable while ready is low; exactly 4 transfers occur; `trace_last_o` occurs once.
- **Overflow:** Depth=4, ready=0, 6 consecutive valid records → `fifo_level_o`=4 and `drop_cnt_o`=2. Then ready=1, drain, and one more record → the 5th drained record begins with DROP word 0xD000_0002, then its HDR.
- **Full with simultaneous pop:** level=4 and the final word of the head is accepted in the same cycle as a new `rvfi_valid` → the new record is dropped; the level becomes 3; `drop_cnt_o` increments.
- **Reset mid-record:** assert `rst_i` after beat 2 of a record → the next cycle shows `trace_valid_o`=0, level=0, `drop_cnt_o`=0; the next record starts with HDR.

Source files
------------

// File: rtl/ibexc_rvfi_trace_packer_if.sv
// RVFI retire record inputs plus the packed trace word stream of the trace packer.
// master: the packer (consumes RVFI, drives the stream); slave: the core/sink side.
interface ibexc_rvfi_trace_packer_if;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap;
  logic        rvfi_intr;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic [31:0] rvfi_mem_addr;
  logic [3:0]  rvfi_mem_rmask;
  logic [3:0]  rvfi_mem_wmask;
  logic        rvfi_mem_is_cap;

  logic        trace_valid_o;
  logic        trace_ready_i;
  logic [31:0] trace_data_o;
  logic        trace_last_o;

  modport master (
    input  rvfi_valid, rvfi_order, rvfi_pc_rdata, rvfi_insn, rvfi_trap, rvfi_intr,
    input  rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
    input  rvfi_mem_is_cap,
    input  trace_ready_i,
    output trace_valid_o, trace_data_o, trace_last_o
  );

  modport slave (
    output rvfi_valid, rvfi_order, rvfi_pc_rdata, rvfi_insn, rvfi_trap, rvfi_intr,
    output rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
    output rvfi_mem_is_cap,
    output trace_ready_i,
    input  trace_valid_o, trace_data_o, trace_last_o
  );
endinterface

// File: rtl/ibexc_rvfi_trace_packer.sv
// Buffers RVFI retire records in a small FIFO and serializes each into 3-6 trace words.
// The core is never stalled: records arriving at a full FIFO are dropped and reported in-band.
module ibexc_rvfi_trace_packer #(
  parameter int unsigned Depth    = 4,
  parameter int unsigned DropCntW = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  ibexc_rvfi_trace_packer_if.master    bus,
  output logic [DropCntW-1:0]          drop_cnt_o,
  output logic [$clog2(Depth+1)-1:0]   fifo_level_o
);

  localparam int unsigned LvlW = $clog2(Depth + 1);
  localparam int unsigned PtrW = $clog2(Depth);

  typedef struct packed {
    logic [DropCntW-1:0] drops;
    logic                trap;
    logic                intr;
    logic                is_cap;
    logic [4:0]          rd_addr;
    logic [3:0]          rmask;
    logic [3:0]          wmask;
    logic [9:0]          order;
    logic [31:0]         pc;
    logic [31:0]         insn;
    logic [31:0]         rd_wdata;
    logic [31:0]         mem_addr;
  } rec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DROP,
    S_HDR,
    S_PC,
    S_INSN,
    S_RD,
    S_MEM
  } state_e;

  function automatic logic [DropCntW-1:0] sat_inc(input logic [DropCntW-1:0] v);
    return (v == '1) ? v : v + DropCntW'(1);
  endfunction

  function automatic state_e first_state(input logic [DropCntW-1:0] drops);
    return (drops != '0) ? S_DROP : S_HDR;
  endfunction

  function automatic logic has_rd(input rec_t r);
    return r.rd_addr != 5'd0;
  endfunction

  function automatic logic has_mem(input rec_t r);
    return (r.rmask | r.wmask) != 4'd0;
  endfunction

  state_e              state_q, state_d;
  logic [LvlW-1:0]     level_q, level_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DropCntW-1:0] pend_drop_q, pend_drop_d;
  logic [DropCntW-1:0] drop_cnt_q, drop_cnt_d;
  rec_t                mem_q [Depth];

  logic capture, full, push, drop, fire, pop;
  rec_t in_rec, head, next_rec;
  state_e after_rec;
  logic unused_order;

  assign unused_order = ^bus.rvfi_order[63:10];

  // ---- capture / FIFO control ----
  assign capture = bus.rvfi_valid & enable_i;
  assign full    = (level_q == LvlW'(Depth));
  assign push    = capture & ~full;
  assign drop    = capture & full;
  assign fire    = bus.trace_valid_o & bus.trace_ready_i;
  assign pop     = fire & bus.trace_last_o;

  always_comb begin
    in_rec          = '0;
    in_rec.drops    = pend_drop_q;
    in_rec.trap     = bus.rvfi_trap;
    in_rec.intr     = bus.rvfi_intr;
    in_rec.is_cap   = bus.rvfi_mem_is_cap;
    in_rec.rd_addr  = bus.rvfi_rd_addr;
    in_rec.rmask    = bus.rvfi_mem_rmask;
    in_rec.wmask    = bus.rvfi_mem_wmask;
    in_rec.order    = bus.rvfi_order[9:0];
    in_rec.pc       = bus.rvfi_pc_rdata;
    in_rec.insn     = bus.rvfi_insn;
    in_rec.rd_wdata = bus.rvfi_rd_wdata;
    in_rec.mem_addr = bus.rvfi_mem_addr;
  end

  assign head     = mem_q[rd_ptr_q];
  assign next_rec = mem_q[rd_ptr_q + PtrW'(1)];

  always_comb begin
    level_d     = level_q + LvlW'(push) - LvlW'(pop);
    wr_ptr_d    = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    pend_drop_d = pend_drop_q;
    drop_cnt_d  = drop_cnt_q;
    if (push) begin
      pend_drop_d = '0;
    end else if (drop) begin
      pend_drop_d = sat_inc(pend_drop_q);
      drop_cnt_d  = sat_inc(drop_cnt_q);
    end
  end

  // ---- state and control registers ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pend_drop_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pend_drop_q <= pend_drop_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_rec;
    end
  end

  // ---- next-state ----
  // The record that follows a finished one may be the entry being pushed this very
  // edge, so it is taken from the capture inputs to avoid an inter-record bubble.
  always_comb begin
    if (level_q > LvlW'(1)) begin
      after_rec = first_state(next_rec.drops);
    end else if (push) begin
      after_rec = first_state(pend_drop_q);
    end else begin
      after_rec = S_IDLE;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          state_d = first_state(head.drops);
        end else if (push) begin
          state_d = first_state(pend_drop_q);
        end
      end
      S_DROP: if (fire) state_d = S_HDR;
      S_HDR:  if (fire) state_d = S_PC;
      S_PC:   if (fire) state_d = S_INSN;
      S_INSN: begin
        if (fire) begin
          if (has_rd(head))       state_d = S_RD;
          else if (has_mem(head)) state_d = S_MEM;
          else                    state_d = after_rec;
        end
      end
      S_RD: begin
        if (fire) state_d = has_mem(head) ? S_MEM : after_rec;
      end
      S_MEM:  if (fire) state_d = after_rec;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- output select ----
  always_comb begin
    bus.trace_valid_o = 1'b0;
    bus.trace_data_o  = '0;
    bus.trace_last_o  = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_DROP: begin
        bus.trace_valid_o = 1'b1;
        bus.trace_data_o  = 32'hD000_0000 | 32'(head.drops);
      end
      S_HDR: begin
        bus.trace_valid_o = 1'b1;
        bus.trace_data_o  = {4'hA, head.trap, head.intr, has_rd(head), has_mem(head),
                             head.is_cap, head.rd_addr, head.rmask, head.wmask, head.order};
      end
      S_PC: begin
        bus.trace_valid_o = 1'b1;
        bus.trace_data_o  = head.pc;
      end
      S_INSN: begin
        bus.trace_valid_o = 1'b1;
        bus.trace_data_o  = head.insn;
        bus.trace_last_o  = ~has_rd(head) & ~has_mem(head);
      end
      S_RD: begin
        bus.trace_valid_o = 1'b1;
        bus.trace_data_o  = head.rd_wdata;
        bus.trace_last_o  = ~has_mem(head);
      end
      S_MEM: begin
        bus.trace_valid_o = 1'b1;
        bus.trace_data_o  = head.mem_addr;
        bus.trace_last_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign drop_cnt_o   = drop_cnt_q;
  assign fifo_level_o = level_q;

endmodule
